// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: two requesters share one bitwise logic unit (AND/OR/XOR/NOR).
// A round-robin arbiter grants the unit, operands are captured at grant, and the
// result is registered one cycle later and flagged with a one-cycle done pulse.
// Optional feature macro: LOGIC_ARB_ZERO_FLAG_EN adds a registered 'zero' output
// that is high when the loaded result is all-zero.
module logic_op_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       gnt,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] res,
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] unit_out;
    logic             pick1;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif

    // Shared logic unit, always fed from the captured operands and op.
    always_comb begin
        unit_out = '0;
        case (op_q)
            2'b00:   unit_out = a_q & b_q;
            2'b01:   unit_out = a_q | b_q;
            2'b10:   unit_out = a_q ^ b_q;
            default: unit_out = ~(a_q | b_q);
        endcase
    end

    // Next-state logic: round-robin grant with capture, result load, done pulse.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        res_d   = res_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        pick1   = 1'b0;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        zero_d  = zero_q;
`endif
        case (state_q)
            IDLE: begin
                // last_q high means requester 1 was served last, so 0 wins a tie.
                pick1 = req1 & (~req0 | ~last_q);
                if (req0 | req1) begin
                    state_d = EXEC;
                    gnt_d   = pick1 ? 2'b10 : 2'b01;
                    a_d     = pick1 ? a1 : a0;
                    b_d     = pick1 ? b1 : b0;
                    op_d    = pick1 ? op1 : op0;
                end
            end
            EXEC: begin
                state_d = DONE;
                res_d   = unit_out;
                done0_d = gnt_q[0];
                done1_d = gnt_q[1];
                last_d  = gnt_q[1];
`ifdef LOGIC_ARB_ZERO_FLAG_EN
                zero_d  = (unit_out == '0);
`endif
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // State and output registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            res_q   <= '0;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'b00;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            res_q   <= res_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign gnt   = gnt_q;
    assign done0 = done0_q;
    assign done1 = done1_q;
    assign res   = res_q;
    assign busy  = (state_q != IDLE);
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    assign zero  = zero_q;
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb_logic_op_arbiter: scoreboard bench for logic_op_arbiter. A transaction-level
// model predicts each grant and its result; a monitor pops and compares on done.
// Honours LOGIC_ARB_ZERO_FLAG_EN when defined for the optional zero output.
module tb_logic_op_arbiter;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             req0, req1;
    logic [1:0]       op0, op1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic [1:0]       gnt;
    logic             done0, done1;
    logic [WIDTH-1:0] res;
    logic             busy;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    logic             zero;
`endif

    logic_op_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0),
        .req1  (req1),
        .op0   (op0),
        .op1   (op1),
        .a0    (a0),
        .b0    (b0),
        .a1    (a1),
        .b1    (b1),
        .gnt   (gnt),
        .done0 (done0),
        .done1 (done1),
        .res   (res),
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        .zero  (zero),
`endif
        .busy  (busy)
    );

    typedef struct {
        int               who;
        logic [WIDTH-1:0] res;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    int               m_cnt  = 0;
    int               m_last = 1;
    int               wait_cnt = 0;
    logic [WIDTH-1:0] last_res = '0;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] calc(input logic [1:0] op,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
        case (op)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    // Drive one cycle of inputs and let the model decide whether the next edge grants.
    task automatic applyStimulus(input logic r0, input logic r1,
                                 input logic [1:0] o0, input logic [1:0] o1,
                                 input logic [WIDTH-1:0] x0, input logic [WIDTH-1:0] y0,
                                 input logic [WIDTH-1:0] x1, input logic [WIDTH-1:0] y1);
        exp_t e;
        @(negedge clk);
        req0 = r0; req1 = r1; op0 = o0; op1 = o1;
        a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        if (m_cnt > 0) begin
            m_cnt--;
        end else if (r0 || r1) begin
            if (r0 && r1) e.who = (m_last == 1) ? 0 : 1;
            else          e.who = r0 ? 0 : 1;
            e.res  = (e.who == 0) ? calc(o0, x0, y0) : calc(o1, x1, y1);
            sb.push_back(e);
            m_last = e.who;
            m_cnt  = 2;
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, '0, '0, '0, '0);
    endtask

    task automatic flushModel();
        sb.delete();
        m_cnt    = 0;
        m_last   = 1;
        wait_cnt = 0;
        last_res = '0;
    endtask

    // Monitor: invariants every cycle, scoreboard pop and compare on each done.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            checkOutput("gnt_not_11", {31'd0, gnt == 2'b11}, '0);
            checkOutput("done_exclusive", {31'd0, done0 & done1}, '0);
            if (done0 || done1) begin
                wait_cnt = 0;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", {30'd0, done1, done0}, '0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("done_who", {30'd0, done1, done0}, (e.who == 0) ? 2 'b01 : 2'b10);
                    checkOutput("gnt_at_done", {30'd0, gnt}, (e.who == 0) ? 2'b01 : 2'b10);
                    checkOutput("busy_at_done", {31'd0, busy}, 1);
                    checkOutput("res", res, e.res);
`ifdef LOGIC_ARB_ZERO_FLAG_EN
                    checkOutput("zero", {31'd0, zero}, {31'd0, e.res == '0});
`endif
                    last_res = e.res;
                end
            end else begin
                checkOutput("res_hold", res, last_res);
                if (sb.size() != 0) begin
                    wait_cnt++;
                    if (wait_cnt > 6) begin
                        checkOutput("done_timeout", {31'd0, done0 | done1}, 1);
                        void'(sb.pop_front());
                        wait_cnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req0 = 0; req1 = 0; op0 = 0; op1 = 0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        #1;
        checkOutput("rst_gnt", {30'd0, gnt}, 0);
        checkOutput("rst_done", {30'd0, done1, done0}, 0);
        checkOutput("rst_res", res, 0);
        checkOutput("rst_busy", {31'd0, busy}, 0);
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        checkOutput("rst_zero", {31'd0, zero}, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single OR request; operands changed after grant must not matter.
        applyStimulus(1'b1, 1'b0, 2'b01, 2'b00, 32'h0000FFFF, 32'h00FF00FF, '0, '0);
        applyStimulus(1'b0, 1'b0, 2'b11, 2'b00, 32'h12345678, 32'h9ABCDEF0, '0, '0);
        checkOutput("d030_gnt", {30'd0, gnt}, 2'b01);
        checkOutput("d030_busy", {31'd0, busy}, 1);
        idleCycle();
        checkOutput("d030_done0", {31'd0, done0}, 1);
        checkOutput("d030_res", res, 32'h00FFFFFF);
        idleCycle();
        checkOutput("d030_gnt_clear", {30'd0, gnt}, 0);

        // NOR of zeros, then back-to-back requester 1 with AND of zeros.
        applyStimulus(1'b0, 1'b1, 2'b00, 2'b11, '0, '0, 32'h0, 32'h0);
        idleCycle();
        checkOutput("d034_gnt", {30'd0, gnt}, 2'b10);
        idleCycle();
        checkOutput("d034_res_nor", res, 32'hFFFFFFFF);
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        checkOutput("d034_zero0", {31'd0, zero}, 0);
`endif
        applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, '0, '0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, '0, '0, 32'h0, 32'h0);
        checkOutput("d032_regrant", {30'd0, gnt}, 2'b10);
        idleCycle();
        checkOutput("d034_res_and", res, 32'h0);
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        checkOutput("d034_zero1", {31'd0, zero}, 1);
`endif
        idleCycle();

        // Both requesting: grants alternate starting with requester 0.
        for (int k = 0; k < 18; k++) begin
            applyStimulus(1'b1, 1'b1, 2'b00, 2'b10, 32'hF0F0F0F0, 32'hFF00FF00,
                          32'hF0F0F0F0, 32'hFF00FF00);
            if (k % 3 == 1)
                checkOutput("d031_gnt", {30'd0, gnt}, ((k / 3) % 2 == 0) ? 2'b01 : 2'b10);
            if (k % 3 == 2)
                checkOutput("d031_res", res, ((k / 3) % 2 == 0) ? 32'hF000F000 : 32'h0FF00FF0);
        end
        idleCycle();
        idleCycle();
        idleCycle();

        // Reset during EXEC discards the operation immediately.
        applyStimulus(1'b1, 1'b0, 2'b10, 2'b00, 32'hAAAA5555, 32'h0F0F0F0F, '0, '0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("d033_gnt", {30'd0, gnt}, 0);
        checkOutput("d033_res", res, 0);
        checkOutput("d033_done", {30'd0, done1, done0}, 0);
        checkOutput("d033_busy", {31'd0, busy}, 0);
        flushModel();
        req0 = 0; req1 = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic, including requests that drop and operand churn.
        for (int n = 0; n < 1500; n++) begin
            applyStimulus(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom),
                          WIDTH'($urandom), WIDTH'($urandom),
                          ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom));
        end
        for (int n = 0; n < 8; n++) idleCycle();
        checkOutput("sb_drained", WIDTH'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/logic_op_arbiter.md
LOGIC_OP_ARBITER -- requirements
Module: logic_op_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 Port: clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: req0 / req1  input  1 each  request from requester 0 / 1; held high until its done pulse.
REQ-005 Port: op0 / op1  input  2 each  operation select: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-006 Port: a0, b0 / a1, b1  input  WIDTH each  operands for requester 0 / 1.
REQ-007 Port: gnt  output  2  one-hot grant, bit i = requester i owns the shared logic unit.
REQ-008 Port: done0 / done1  output  1 each  one-cycle pulse: result valid for requester 0 / 1.
REQ-009 Port: res  output  WIDTH  registered result; holds its value until the next completion.
REQ-010 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-011 The block SHALL contain one shared combinational logic unit implementing AND, OR, XOR and NOR, selected by the granted requester's op.
REQ-012 The FSM SHALL have three states: IDLE, EXEC and DONE.
REQ-013 IDLE -> EXEC SHALL occur when req0 or req1 is high; the grant and the operand/op capture occur on the same edge.
REQ-014 EXEC -> DONE SHALL occur unconditionally after one cycle; on that edge res SHALL load the unit output computed from the captured operands.
REQ-015 In DONE, the granted requester's done pulse SHALL be high for exactly one cycle; DONE -> IDLE SHALL follow unconditionally.
REQ-016 Latency SHALL be 2 cycles from the grant edge to done; the minimum issue interval SHALL be 3 cycles.
REQ-017 Operands and op SHALL be captured into internal registers at grant, so input changes after grant have no effect on the result.
REQ-018 Arbitration SHALL be round-robin. When both requests are high in IDLE, grant goes to the requester not served last. After reset, requester 0 has priority.
REQ-019 A single active request SHALL be granted regardless of round-robin priority.
REQ-020 gnt SHALL stay stable from grant until the DONE -> IDLE transition, then clear to 00.
REQ-021 A request that drops before grant SHALL be ignored.
REQ-022 A request that drops after grant SHALL NOT abort the operation; done still pulses.
REQ-023 done0 and done1 SHALL never be high simultaneously, and gnt SHALL never be 11.
REQ-024 Result width SHALL be exactly WIDTH, with no carry or extension; NOR SHALL be the bitwise inverse of OR.

Reset
REQ-025 While rst_n is low, the following SHALL be forced immediately, without waiting for a clock edge: state=IDLE, gnt=00, done0=done1=0, res=0, busy=0, last-served=requester 1 (giving requester 0 priority), captured operands=0.
REQ-026 Reset asserted mid-operation SHALL discard the operation with no done pulse. After release, pending requests are re-arbitrated from IDLE.
REQ-027 Release of rst_n SHALL take effect on the first rising clk edge with rst_n high.

Configuration
REQ-028 Macro LOGIC_ARB_ZERO_FLAG_EN defined: an extra output zero (1 bit) SHALL be present. It is registered with res, equals 1 when the loaded res is all-zero, and resets to 0.
REQ-029 Macro LOGIC_ARB_ZERO_FLAG_EN undefined: the zero port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-030 Scenario: reset, then req0=1, op0=01, a0=0x0000FFFF, b0=0x00FF00FF. Required: gnt=01, then done0 two cycles after grant, res=0x00FFFFFF.
REQ-031 Scenario: req0 and req1 both held high, op0=00 (AND), op1=10 (XOR), a=0xF0F0F0F0, b=0xFF00FF00 for both. Required: grants alternate 01, 10, 01, ...; results alternate 0xF000F000 and 0x0FF00FF0.
REQ-032 Scenario: only req1 high after a requester-1 completion. Required: requester 1 is granted again with no idle stall.
REQ-033 Scenario: rst_n pulled low in EXEC. Required: gnt=00 and res=0 immediately, with no done pulse.
REQ-034 Scenario: op=11 (NOR), a=b=0x00000000. Required: res=0xFFFFFFFF. With LOGIC_ARB_ZERO_FLAG_EN defined, zero=0; with op=00 on the same operands, zero=1.
REQ-035 Scenario: change a0 and b0 one cycle after grant. Required: res reflects the originally captured values.
